// File: rtl/offset_pkg.sv
// Shared constants for the on-screen character-block window controller.
package offset_pkg;

  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;

  // Character glyphs are 8x8; the block is scaled 8x horizontally, 4x vertically.
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 8;
  localparam int SCALE_X   = 8;
  localparam int SCALE_Y   = 4;
  localparam int DEF_BLK_W = CHAR_W * SCALE_X;
  localparam int DEF_BLK_H = CHAR_H * SCALE_Y;

  localparam int DIR_UP     = 0;
  localparam int DIR_DOWN   = 1;
  localparam int DIR_LEFT   = 2;
  localparam int DIR_RIGHT  = 3;
  localparam int Q_RECENTER = 4;
  localparam int QUEUE_W    = 5;

  function automatic int centrePos(input int res, input int blk);
    return (res - blk) / 2;
  endfunction

endpackage

// File: rtl/axis_pos_step.sv
// One screen axis: steps, wraps or clamps the window start and derives end/wrap.
module axis_pos_step
  import offset_pkg::*;
#(
  parameter int RES       = DEF_H_RES,
  parameter int BLK       = DEF_BLK_W,
  parameter int STEP      = 64,
  parameter int WRAP_MODE = 1,
  parameter int COORD_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] curStart,
  input  logic               dec,
  input  logic               inc,
  input  logic               apply,
  input  logic               recenter,
  output logic [COORD_W-1:0] startPos,
  output logic [COORD_W-1:0] endPos,
  output logic               wrapFlag
);

  localparam int W1 = COORD_W + 1;
  localparam logic [W1-1:0] RES_X  = W1'(RES);
  localparam logic [W1-1:0] BLK_X  = W1'(BLK);
  localparam logic [W1-1:0] STEP_X = W1'(STEP);
  localparam logic [W1-1:0] MAXS_X = W1'(RES - BLK);
  localparam logic [W1-1:0] CTR_X  = W1'(centrePos(RES, BLK));
  localparam logic [COORD_W-1:0] CTR_START = COORD_W'(centrePos(RES, BLK));
  localparam logic [COORD_W-1:0] CTR_END   = COORD_W'(centrePos(RES, BLK) + BLK - 1);

  logic [W1-1:0] s, sNext, eSum, eNext;

  // One extra bit keeps s+STEP and s+BLK-1 exact before the range compare.
  always_comb begin
    // NOTE: every variable gets a default first so this block can never infer a latch.
    s     = {1'b0, curStart};
    sNext = s;
    if (recenter) begin
      sNext = CTR_X;
    end else if (dec && !inc) begin
      if (s >= STEP_X)        sNext = s - STEP_X;
      else if (WRAP_MODE != 0) sNext = s + RES_X - STEP_X;
      else                    sNext = '0;
    end else if (inc && !dec) begin
      if (WRAP_MODE != 0) sNext = (s + STEP_X >= RES_X) ? s + STEP_X - RES_X : s + STEP_X;
      else                sNext = (s + STEP_X > MAXS_X) ? MAXS_X : s + STEP_X;
    end
    eSum  = sNext + BLK_X - W1'(1);
    eNext = (eSum >= RES_X) ? eSum - RES_X : eSum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      startPos <= CTR_START;
      endPos   <= CTR_END;
      wrapFlag <= 1'b0;
    end else if (apply) begin
      startPos <= sNext[COORD_W-1:0];
      endPos   <= eNext[COORD_W-1:0];
      wrapFlag <= (WRAP_MODE != 0) && (eNext < sNext);
    end
  end

endmodule

// File: rtl/offset_window_ctrl.sv
// Moves the character-block window on debounced key requests, with auto-repeat,
// recenter and optional frame-synchronous application. Requires 2^COORD_W > max(H_RES, V_RES).
module offset_window_ctrl
  import offset_pkg::*;
#(
  parameter int          H_RES      = DEF_H_RES,
  parameter int          V_RES      = DEF_V_RES,
  parameter int          BLK_W      = DEF_BLK_W,
  parameter int          BLK_H      = DEF_BLK_H,
  parameter int          STEP_H     = 64,
  parameter int          STEP_V     = 32,
  parameter int          COORD_W    = 10,
  parameter int          WRAP_MODE  = 1,
  parameter int          FRAME_SYNC = 1,
  parameter logic [23:0] HOLD_CYC   = 24'd12_500_000,
  parameter logic [23:0] RPT_CYC    = 24'd2_500_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         move_req,
  input  logic               recenter,
  input  logic               frame_tick,
  output logic [COORD_W-1:0] hor_start,
  output logic [COORD_W-1:0] hor_end,
  output logic [COORD_W-1:0] ver_start,
  output logic [COORD_W-1:0] ver_end,
  output logic               hor_wrap,
  output logic               ver_wrap,
  output logic               pending
);

  logic [3:0]         move_req_q, evt, rptEvt;
  logic [23:0]        rptCnt;
  logic [QUEUE_W-1:0] queueQ, queueNext;
  logic               stable, rptFire, applyNow;

  assign evt       = move_req & ~move_req_q;
  assign stable    = (move_req == move_req_q) && (move_req != '0);
  assign rptFire   = stable && (rptCnt == HOLD_CYC);
  assign rptEvt    = rptFire ? move_req : '0;
  // Events arriving in the apply cycle are folded in and applied on that same edge.
  assign queueNext = queueQ | {recenter, evt | rptEvt};
  assign applyNow  = (FRAME_SYNC != 0) ? frame_tick : 1'b1;
  assign pending   = |queueQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      move_req_q <= '0;
      rptCnt     <= '0;
      queueQ     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      move_req_q <= move_req;
      if (!stable)      rptCnt <= '0;
      else if (rptFire) rptCnt <= HOLD_CYC - RPT_CYC + 24'd1;  // next hit RPT_CYC cycles on
      else              rptCnt <= rptCnt + 24'd1;
      queueQ <= applyNow ? '0 : queueNext;
    end
  end

  axis_pos_step #(
    .RES(H_RES), .BLK(BLK_W), .STEP(STEP_H), .WRAP_MODE(WRAP_MODE), .COORD_W(COORD_W)
  ) horAxis (
    .clk      (clk),
    .reset    (reset),
    .curStart (hor_start),
    .dec      (queueNext[DIR_LEFT]),
    .inc      (queueNext[DIR_RIGHT]),
    .apply    (applyNow),
    .recenter (queueNext[Q_RECENTER]),
    .startPos (hor_start),
    .endPos   (hor_end),
    .wrapFlag (hor_wrap)
  );

  axis_pos_step #(
    .RES(V_RES), .BLK(BLK_H), .STEP(STEP_V), .WRAP_MODE(WRAP_MODE), .COORD_W(COORD_W)
  ) verAxis (
    .clk      (clk),
    .reset    (reset),
    .curStart (ver_start),
    .dec      (queueNext[DIR_UP]),
    .inc      (queueNext[DIR_DOWN]),
    .apply    (applyNow),
    .recenter (queueNext[Q_RECENTER]),
    .startPos (ver_start),
    .endPos   (ver_end),
    .wrapFlag (ver_wrap)
  );

endmodule

// File: tb/tb_offset_window_ctrl.sv
// Bench: wrap/frame-sync instance A and clamp/immediate/fast-repeat instance B vs. a modular-arithmetic model.
module tb_offset_window_ctrl;
  import offset_pkg::*;

  localparam int HR = 640, VR = 480, BW = 64, BH = 32;
  localparam int SH = 64, SV = 32, CH = 288, CV = 224;
  localparam int HOLD = 4, RPT = 2;
  localparam logic [3:0] M_UP    = 4'b0001;
  localparam logic [3:0] M_DOWN  = 4'b0010;
  localparam logic [3:0] M_LEFT  = 4'b0100;
  localparam logic [3:0] M_RIGHT = 4'b1000;
  localparam logic [41:0] CENTRE = {10'd288, 10'd351, 10'd224, 10'd255, 2'b00};

  logic clk = 1'b0;
  logic reset;
  logic [3:0] reqA, reqB;
  logic recA, tickA, recB, tickB;
  logic [9:0] hsA, heA, vsA, veA, hsB, heB, vsB, veB;
  logic hwA, vwA, pendA, hwB, vwB, pendB;
  logic [41:0] winA, winB;

  assign winA = {hsA, heA, vsA, veA, hwA, vwA};
  assign winB = {hsB, heB, vsB, veB, hwB, vwB};

  always #5 clk = ~clk;

  offset_window_ctrl dutA (
    .clk(clk), .reset(reset), .move_req(reqA), .recenter(recA), .frame_tick(tickA),
    .hor_start(hsA), .hor_end(heA), .ver_start(vsA), .ver_end(veA),
    .hor_wrap(hwA), .ver_wrap(vwA), .pending(pendA)
  );

  offset_window_ctrl #(
    .WRAP_MODE(0), .FRAME_SYNC(0), .HOLD_CYC(24'd4), .RPT_CYC(24'd2)
  ) dutB (
    .clk(clk), .reset(reset), .move_req(reqB), .recenter(recB), .frame_tick(tickB),
    .hor_start(hsB), .hor_end(heB), .ver_start(vsB), .ver_end(veB),
    .hor_wrap(hwB), .ver_wrap(vwB), .pending(pendB)
  );

  int errors = 0;
  int checks = 0;
  int mh = CH, mv = CV;

  function automatic logic [41:0] expWin(input int hs, input int vs);
    int he, ve;
    he = (hs + BW - 1) % HR;
    ve = (vs + BH - 1) % VR;
    return {10'(hs), 10'(he), 10'(vs), 10'(ve), (he < hs), (ve < vs)};
  endfunction

  // Reference model for instance A: modular screen arithmetic.
  task automatic modelApply(input logic [3:0] d, input logic rc);
    if (rc) begin
      mh = CH; mv = CV;
    end else begin
      if (d[DIR_LEFT] != d[DIR_RIGHT])
        mh = d[DIR_LEFT] ? (mh - SH + HR) % HR : (mh + SH) % HR;
      if (d[DIR_UP] != d[DIR_DOWN])
        mv = d[DIR_UP] ? (mv - SV + VR) % VR : (mv + SV) % VR;
    end
  endtask

  task automatic pressA(input logic [3:0] d, input logic rc);
    @(negedge clk); reqA = d; recA = rc;
    @(negedge clk); reqA = '0; recA = 1'b0;
  endtask

  task automatic tickPulseA(input logic [3:0] d, input logic rc);
    @(negedge clk); tickA = 1'b1; reqA = d; recA = rc;
    @(negedge clk); tickA = 1'b0; reqA = '0; recA = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (winA !== CENTRE) begin
      errors++; $display("FAIL reset_hold_A: got %h expected %h", winA, CENTRE);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (winA !== CENTRE || pendA !== 1'b0) begin
      errors++; $display("FAIL reset_release_A: got %h pend %b expected %h pend 0", winA, pendA, CENTRE);
    end
    checks++;
    if (winB !== CENTRE || pendB !== 1'b0) begin
      errors++; $display("FAIL reset_release_B: got %h pend %b expected %h pend 0", winB, pendB, CENTRE);
    end
  endtask

  task automatic test_single_left();
    pressA(M_LEFT, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (pendA !== 1'b1 || hsA !== 10'd288) begin
        errors++; $display("FAIL queued_left cyc %0d: pend %b hs %0d expected pend 1 hs 288", i, pendA, hsA);
      end
    end
    tickPulseA('0, 1'b0);
    modelApply(M_LEFT, 1'b0);
    checks++;
    if (winA !== {10'd224, 10'd287, 10'd224, 10'd255, 2'b00} || pendA !== 1'b0) begin
      errors++; $display("FAIL single_left: got %h pend %b expected %h pend 0", winA, pendA, expWin(mh, mv));
    end
  endtask

  task automatic test_edge_wrap();
    tickPulseA('0, 1'b1);
    modelApply('0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      pressA(M_LEFT, 1'b0);
      tickPulseA('0, 1'b0);
      modelApply(M_LEFT, 1'b0);
      checks++;
      if (winA !== expWin(mh, mv)) begin
        errors++; $display("FAIL left_step %0d: got %h expected %h", i, winA, expWin(mh, mv));
      end
    end
    checks++;
    if (hsA !== 10'd608 || heA !== 10'd31 || hwA !== 1'b1) begin
      errors++; $display("FAIL left_wrap: got %0d/%0d w%b expected 608/31 w1", hsA, heA, hwA);
    end
    tickPulseA('0, 1'b1);
    modelApply('0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      pressA(M_UP, 1'b0);
      tickPulseA('0, 1'b0);
      modelApply(M_UP, 1'b0);
      checks++;
      if (winA !== expWin(mh, mv)) begin
        errors++; $display("FAIL up_step %0d: got %h expected %h", i, winA, expWin(mh, mv));
      end
      if (i == 7) begin
        checks++;
        if (vsA !== 10'd0 || veA !== 10'd31) begin
          errors++; $display("FAIL up_top: got %0d/%0d expected 0/31", vsA, veA);
        end
      end
    end
    checks++;
    if (vsA !== 10'd448 || veA !== 10'd479 || vwA !== 1'b0) begin
      errors++; $display("FAIL up_wrap: got %0d/%0d w%b expected 448/479 w0", vsA, veA, vwA);
    end
  endtask

  task automatic test_cancel_recenter();
    tickPulseA('0, 1'b1);
    modelApply('0, 1'b1);
    pressA(M_UP | M_DOWN | M_RIGHT, 1'b0);
    tickPulseA('0, 1'b0);
    checks++;
    if (winA !== {10'd352, 10'd415, 10'd224, 10'd255, 2'b00}) begin
      errors++; $display("FAIL cancel_axis: got %h expected 352/415 224/255", winA);
    end
    pressA(M_LEFT, 1'b0);
    pressA('0, 1'b1);
    tickPulseA('0, 1'b0);
    mh = CH; mv = CV;
    checks++;
    if (winA !== CENTRE || pendA !== 1'b0) begin
      errors++; $display("FAIL recenter_wins: got %h pend %b expected %h pend 0", winA, pendA, CENTRE);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [3:0] accD, d;
      logic accR, rc;
      int n;
      accD = '0; accR = 1'b0;
      n = $urandom_range(1, 3);
      for (int p = 0; p < n; p++) begin
        d  = 4'($urandom);
        rc = ($urandom_range(0, 7) == 0);
        accD |= d; accR |= rc;
        pressA(d, rc);
      end
      checks++;
      if (pendA !== ((accD != '0) || accR)) begin
        errors++; $display("FAIL rand_pending %0d: got %b expected %b", it, pendA, (accD != '0) || accR);
      end
      d  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      rc = ($urandom_range(0, 9) == 0);
      accD |= d; accR |= rc;
      tickPulseA(d, rc);
      modelApply(accD, accR);
      checks++;
      if (winA !== expWin(mh, mv) || pendA !== 1'b0) begin
        errors++; $display("FAIL rand_apply %0d: got %h pend %b expected %h pend 0", it, winA, pendA, expWin(mh, mv));
      end
    end
  endtask

  task automatic test_clamp_repeat();
    int steps, hs;
    @(negedge clk); reqB = M_LEFT;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      steps = 1 + ((k >= HOLD + 1) ? 1 + (k - HOLD - 1) / RPT : 0);
      hs = CH - SH * steps;
      if (hs < 0) hs = 0;
      checks++;
      if (winB !== expWin(hs, CV)) begin
        errors++; $display("FAIL clamp_repeat k=%0d: got %h expected %h", k, winB, expWin(hs, CV));
      end
    end
    reqB = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (hsB !== 10'd0 || heB !== 10'd63 || hwB !== 1'b0) begin
        errors++; $display("FAIL clamp_release: got %0d/%0d w%b expected 0/63 w0", hsB, heB, hwB);
      end
    end
  endtask

  task automatic test_reset_midop();
    pressA(M_LEFT, 1'b0);
    checks++;
    if (pendA !== 1'b1) begin
      errors++; $display("FAIL pre_reset_pending: got %b expected 1", pendA);
    end
    @(negedge clk); reqB = M_RIGHT;
    repeat (7) @(negedge clk);
    checks++;
    if (hsB !== 10'd128) begin
      errors++; $display("FAIL pre_reset_B: got %0d expected 128", hsB);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (winA !== CENTRE || pendA !== 1'b0 || winB !== CENTRE) begin
      errors++; $display("FAIL async_reset: A %h pend %b B %h expected %h pend 0", winA, pendA, winB, CENTRE);
    end
    @(negedge clk); reqB = '0;
    @(negedge clk); reset = 1'b1;
    tickPulseA('0, 1'b0);
    mh = CH; mv = CV;
    checks++;
    if (winA !== CENTRE || pendA !== 1'b0) begin
      errors++; $display("FAIL post_reset_A: got %h pend %b expected %h pend 0", winA, pendA, CENTRE);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (winB !== CENTRE) begin
      errors++; $display("FAIL post_reset_B: got %h expected %h", winB, CENTRE);
    end
  endtask

  initial begin
    reset = 1'b0;
    reqA = '0; recA = 1'b0; tickA = 1'b0;
    reqB = '0; recB = 1'b0; tickB = 1'b0;
    test_reset();
    test_single_left();
    test_edge_wrap();
    test_cancel_recenter();
    test_random();
    test_clamp_repeat();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/offset_window_ctrl.md
Name: offset_window_ctrl

Overview:
- Clocked, parametrised successor of the character-block position handler.
- Holds the on-screen window (start/end on both axes) where the scaled character block is drawn, and moves it on Up/Down/Left/Right requests.
- Adds over the previous generation: a single synchronous clock domain, configurable resolution/block/step sizes, wrap or clamp edge mode, frame-synchronous updates (no tearing), auto-repeat on held keys, and a recenter command.
- Sits between the button/debounce front end and the pixel-address/readEn generator.

Parameters:
- H_RES, 640, horizontal active pixels
- V_RES, 480, vertical active lines
- BLK_W, 64, block width in pixels (character columns × scale)
- BLK_H, 32, block height in lines
- STEP_H, 64, horizontal step per move, 1..H_RES-1
- STEP_V, 32, vertical step per move, 1..V_RES-1
- COORD_W, 10, coordinate width; must satisfy 2^COORD_W > max(H_RES, V_RES)
- WRAP_MODE, 1, 1 = wrap around screen edges, 0 = clamp at edges
- FRAME_SYNC, 1, 1 = apply moves only on frame_tick, 0 = apply on the next clock
- HOLD_CYC, 24'd12_500_000, held-key delay before the first auto-repeat
- RPT_CYC, 24'd2_500_000, auto-repeat period after the first repeat

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- move_req  in  4  level requests {Right, Left, Down, Up}, already debounced
- recenter  in  1  single-cycle pulse: return window to centre
- frame_tick  in  1  single-cycle pulse at start of vertical blanking
- hor_start  out  COORD_W  first pixel column of window
- hor_end  out  COORD_W  last pixel column of window
- ver_start  out  COORD_W  first line of window
- ver_end  out  COORD_W  last line of window
- hor_wrap  out  1  window split across right/left edge (hor_end < hor_start)
- ver_wrap  out  1  window split across bottom/top edge
- pending  out  1  at least one move or recenter is queued, not yet applied

Behaviour:
- Reset (reset low, asynchronous):
  - hor_start = (H_RES-BLK_W)/2, hor_end = hor_start+BLK_W-1.
  - ver_start = (V_RES-BLK_H)/2, ver_end = ver_start+BLK_H-1.
  - Wrap flags = 0, pending = 0, repeat counter and queue cleared, move_req_q = 0.
  - A reset mid-operation discards anything queued.
- Edge detect: move_req_q registers move_req. evt = move_req & ~move_req_q.
- Auto-repeat:
  - One shared counter, cleared whenever move_req != move_req_q or move_req == 0.
  - While move_req is stable and nonzero, the counter counts. At HOLD_CYC it emits a repeat event for every set bit, then reloads so later repeats come every RPT_CYC.
- Queue:
  - One pending bit per direction plus a recenter bit. Events OR into the queue, so multiple events before apply collapse to one step.
  - pending = OR of the queue bits.
- Apply point:
  - FRAME_SYNC=1: the clock edge where frame_tick = 1. An event arriving in that same cycle is also applied.
  - FRAME_SYNC=0: every clock edge.
  - On apply, the queue is cleared. Outputs change on that edge, so latency is 1 clk after the apply point.
- Priority:
  - Recenter overrides all queued moves; result equals the reset values.
  - Opposing bits (Up+Down or Left+Right) cancel on that axis. Axes are independent.
- Arithmetic, wrap mode:
  - Up: s' = (s >= STEP_V) ? s-STEP_V : s+V_RES-STEP_V.
  - Down: s' = (s+STEP_V >= V_RES) ? s+STEP_V-V_RES : s+STEP_V.
  - Horizontal is the same with H_RES/STEP_H.
  - end = s'+BLK-1, minus RES if >= RES. wrap flag = (end < start).
  - All intermediates are COORD_W+1 bits; no truncation before the compare.
- Arithmetic, clamp mode:
  - s' is saturated to [0, RES-BLK]. Wrap flags are constant 0.
- Outputs are registered. start, end and wrap flags always update on the same edge and are never mutually inconsistent.

Decomposition:
- Package offset_pkg holds:
  - default resolution/block constants (H_RES, V_RES, CHM-derived block sizes)
  - direction bit indices DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3
  - a centre-position constant function
- One sub-module axis_pos_step, instantiated twice (horizontal, vertical):
  - params RES, BLK, STEP, WRAP_MODE, COORD_W
  - inputs: current start, dec, inc, apply, recenter
  - outputs: registered start/end/wrap
- Edge-detect, repeat counter and queue live in the top module.

Test Plan (defaults: 640×480, BLK 64×32, steps 64/32, WRAP_MODE=1, FRAME_SYNC=1):
- Release reset, no input -> hor 288/351, ver 224/255, wraps 0, pending 0.
- Left edge, then frame_tick 10 clk later -> pending=1 until tick. hor 224/287 on the edge after the tick; ver unchanged.
- Five Left applies from reset -> hor 32/95, then 608/31 with hor_wrap=1. Seven Up applies -> ver 0/31, then 448/479 with ver_wrap=0.
- Up+Down together plus Right, one tick -> ver unchanged, hor 352/415. Recenter queued with Left -> hor 288/351.
- WRAP_MODE=0, FRAME_SYNC=0, Left held with HOLD_CYC=4, RPT_CYC=2 -> steps at the edge+1, hold+1 and every 2 clk after. hor saturates at 0/63 and the wrap flag stays 0.
- Assert reset low while pending=1 and mid-repeat -> outputs return to centre asynchronously. No step is applied after release until a new edge.
